// File: rtl/icb_mhsa_pkg.sv
// rtl/icb_mhsa_pkg.sv - shared CSR offsets, FSM states and index helpers for the ICB front end
package icb_mhsa_pkg;

    localparam logic [7:0] CSR_CTRL   = 8'h00;
    localparam logic [7:0] CSR_STATUS = 8'h04;
    localparam logic [7:0] CSR_IRQ_EN = 8'h08;
    localparam int         CSR_BASE0  = 16;
    localparam int         DONE_LSB   = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RSP     = 2'd2
    } state_e;

    // Bits needed to index n items; 0 when there is only one.
    function automatic int idx_bits(input int n);
        int b;
        b = 0;
        while ((1 << b) < n) b++;
        return b;
    endfunction

    // Mask with bits [lo, hi) set; empty when lo >= hi.
    function automatic logic [31:0] bit_range(input int lo, input int hi);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 32; i++) begin
            if (i >= lo && i < hi) m[i] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [7:0] in_base_off(input int c);
        return 8'(CSR_BASE0 + 8 * c);
    endfunction

    function automatic logic [7:0] out_base_off(input int c);
        return 8'(CSR_BASE0 + 4 + 8 * c);
    endfunction

endpackage

// File: rtl/icb_mhsa_csr.sv
// rtl/icb_mhsa_csr.sv - per-channel control, status, irq enable and base address registers
module icb_mhsa_csr
    import icb_mhsa_pkg::*;
#(
    parameter int NUM_CH = 2
) (
    input  logic                rst,
    input  logic                clk,
    input  logic                wr_en,
    input  logic [7:0]          addr,
    input  logic [31:0]         wdata,
    input  logic [3:0]          wmask,
    output logic [31:0]         rdata,
    output logic                err,
    input  logic [NUM_CH-1:0]   acc_done,
    output logic [NUM_CH-1:0]   acc_start,
    output logic [NUM_CH*32-1:0] acc_input_base,
    output logic [NUM_CH*32-1:0] acc_output_base,
    output logic [NUM_CH-1:0]   busy,
    output logic                irq
);

    logic [31:0]       in_base  [NUM_CH];
    logic [31:0]       out_base [NUM_CH];
    logic [NUM_CH-1:0] irq_en;
    logic [NUM_CH-1:0] sticky;
    logic [NUM_CH-1:0] start_set;
    logic [NUM_CH-1:0] w1c;
    logic [31:0]       status_word;

    // A start request for a running channel is silently dropped.
    always_comb begin
        start_set = '0;
        w1c       = '0;
        if (wr_en && addr == CSR_CTRL)   start_set = wdata[NUM_CH-1:0] & ~busy;
        if (wr_en && addr == CSR_STATUS) w1c = wdata[DONE_LSB +: NUM_CH];
    end

    always_comb begin
        status_word = '0;
        status_word[NUM_CH-1:0]          = busy;
        status_word[DONE_LSB +: NUM_CH]  = sticky;
    end

    always_comb begin
        rdata = '0;
        err   = 1'b0;
        if (addr == CSR_CTRL) begin
            rdata = '0;
        end else if (addr == CSR_STATUS) begin
            rdata = status_word;
        end else if (addr == CSR_IRQ_EN) begin
            rdata = 32'(irq_en);
        end else begin
            err = 1'b1;
            for (int c = 0; c < NUM_CH; c++) begin
                if (addr == in_base_off(c)) begin
                    rdata = in_base[c];
                    err   = 1'b0;
                end
                if (addr == out_base_off(c)) begin
                    rdata = out_base[c];
                    err   = 1'b0;
                end
            end
        end
    end

    // A done pulse outranks a simultaneous W1C so no completion is ever lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_start <= '0;
            busy      <= '0;
            sticky    <= '0;
            irq_en    <= '0;
            irq       <= 1'b0;
        end else begin
            acc_start <= start_set;
            busy      <= (busy & ~acc_done) | start_set;
            sticky    <= (sticky & ~w1c) | acc_done;
            irq       <= |(sticky & irq_en);
            if (wr_en && addr == CSR_IRQ_EN) irq_en <= wdata[NUM_CH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                in_base[c]  <= '0;
                out_base[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                for (int b = 0; b < 4; b++) begin
                    if (wr_en && wmask[b] && addr == in_base_off(c))
                        in_base[c][8*b +: 8] <= wdata[8*b +: 8];
                    if (wr_en && wmask[b] && addr == out_base_off(c))
                        out_base[c][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_base
        assign acc_input_base[32*c +: 32]  = in_base[c];
        assign acc_output_base[32*c +: 32] = out_base[c];
    end

endmodule

// File: rtl/icb_mhsa_mc.sv
// rtl/icb_mhsa_mc.sv - ICB slave: single-outstanding FSM, CSR decode and SRAM lane mapping
module icb_mhsa_mc
    import icb_mhsa_pkg::*;
#(
    parameter int NUM_CH       = 2,
    parameter int SRAM_DW      = 64,
    parameter int SRAM_AW      = 12,
    parameter int RD_LAT       = 1,
    parameter int SRAM_SEL_BIT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   icb_cmd_valid,
    output logic                   icb_cmd_ready,
    input  logic                   icb_cmd_read,
    input  logic [31:0]            icb_cmd_addr,
    input  logic [31:0]            icb_cmd_wdata,
    input  logic [3:0]             icb_cmd_wmask,
    output logic                   icb_rsp_valid,
    input  logic                   icb_rsp_ready,
    output logic [31:0]            icb_rsp_rdata,
    output logic                   icb_rsp_err,
    output logic [NUM_CH-1:0]      acc_start,
    input  logic [NUM_CH-1:0]      acc_done,
    output logic [NUM_CH*32-1:0]   acc_input_base,
    output logic [NUM_CH*32-1:0]   acc_output_base,
    output logic                   usram_en,
    output logic                   usram_we,
    output logic [SRAM_DW/8-1:0]   usram_wstrb,
    output logic [SRAM_AW-1:0]     usram_addr,
    output logic [SRAM_DW-1:0]     usram_wdata,
    input  logic [SRAM_DW-1:0]     usram_rdata,
    output logic                   irq
);

    localparam int          LANES      = SRAM_DW / 32;
    localparam int          LANE_W     = idx_bits(LANES);
    localparam int          WORD_LSB   = 2 + LANE_W;
    localparam int          STRB_W     = SRAM_DW / 8;
    localparam int          CNT_W      = idx_bits(RD_LAT + 1);
    localparam logic [31:0] UPPER_MASK = bit_range(WORD_LSB + SRAM_AW, SRAM_SEL_BIT);
    localparam logic [31:0] LANE_MASK  = 32'((1 << LANE_W) - 1);

    state_e              state, state_n;
    logic [CNT_W-1:0]    cnt;
    logic [31:0]         rd_lane;
    logic [31:0]         lane_idx;
    logic [NUM_CH-1:0]   busy;
    logic [31:0]         csr_rdata;
    logic                csr_err;
    logic                cmd_hs, rsp_hs;
    logic                is_sram, sram_err, sram_rd, sram_wr, csr_wr;
    logic [STRB_W-1:0]   wstrb_shift;
    logic [SRAM_AW-1:0]  word_addr;
    logic [31:0]         lane_data;
    logic                unused_addr_bits;

    assign icb_cmd_ready = (state == IDLE) && !rst;
    assign icb_rsp_valid = (state == RSP);
    assign cmd_hs        = icb_cmd_valid && icb_cmd_ready;
    assign rsp_hs        = icb_rsp_valid && icb_rsp_ready;

    assign lane_idx    = (icb_cmd_addr >> 2) & LANE_MASK;
    assign word_addr   = SRAM_AW'(icb_cmd_addr >> WORD_LSB);
    assign wstrb_shift = STRB_W'(icb_cmd_wmask) << (4 * lane_idx);
    assign lane_data   = 32'(usram_rdata >> (32 * rd_lane));
    assign unused_addr_bits = ^icb_cmd_addr;

    // Running accelerators own the SRAM, so the bus is locked out while any channel is busy.
    assign is_sram  = icb_cmd_addr[SRAM_SEL_BIT];
    assign sram_err = is_sram && ((|busy) || (|(icb_cmd_addr & UPPER_MASK)) || (lane_idx >= 32'(LANES)));
    assign sram_rd  = cmd_hs && is_sram && !sram_err && icb_cmd_read;
    assign sram_wr  = cmd_hs && is_sram && !sram_err && !icb_cmd_read && (|icb_cmd_wmask);
    assign csr_wr   = cmd_hs && !is_sram && !icb_cmd_read;

    icb_mhsa_csr #(
        .NUM_CH (NUM_CH)
    ) u_csr (
        .rst             (rst),
        .clk             (clk),
        .wr_en           (csr_wr),
        .addr            (icb_cmd_addr[7:0]),
        .wdata           (icb_cmd_wdata),
        .wmask           (icb_cmd_wmask),
        .rdata           (csr_rdata),
        .err             (csr_err),
        .acc_done        (acc_done),
        .acc_start       (acc_start),
        .acc_input_base  (acc_input_base),
        .acc_output_base (acc_output_base),
        .busy            (busy),
        .irq             (irq)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (cmd_hs) state_n = sram_rd ? RD_WAIT : RSP;
            RD_WAIT: if (cnt == CNT_W'(RD_LAT)) state_n = RSP;
            RSP:     if (rsp_hs) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // cnt counts edges after the registered enable; read data is captured RD_LAT cycles later.
    always_ff @(posedge clk) begin
        if (rst) begin
            usram_en      <= 1'b0;
            usram_we      <= 1'b0;
            usram_wstrb   <= '0;
            usram_addr    <= '0;
            usram_wdata   <= '0;
            icb_rsp_rdata <= '0;
            icb_rsp_err   <= 1'b0;
            rd_lane       <= '0;
            cnt           <= '0;
        end else begin
            usram_en    <= sram_rd || sram_wr;
            usram_we    <= sram_wr;
            usram_wstrb <= sram_wr ? wstrb_shift : '0;
            if (sram_rd || sram_wr) begin
                usram_addr  <= word_addr;
                usram_wdata <= {LANES{icb_cmd_wdata}};
            end
            if (cmd_hs) begin
                icb_rsp_err   <= is_sram ? sram_err : csr_err;
                icb_rsp_rdata <= (!is_sram && icb_cmd_read) ? csr_rdata : '0;
                rd_lane       <= lane_idx;
                cnt           <= '0;
            end else if (state == RD_WAIT) begin
                if (cnt == CNT_W'(RD_LAT)) icb_rsp_rdata <= lane_data;
                else                       cnt <= cnt + 1'b1;
            end
        end
    end

endmodule
